// File: rtl/data_mem_unit.sv
// Byte-addressed data memory with a valid/ready request/response handshake.
// Ports: clk, rst_n, req_* (we/size/unsigned/addr/wdata), rsp_* (valid/ready/rdata/err).
module data_mem_unit #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int          NB    = DEPTH * 8;
  localparam int          AW    = $clog2(NB);
  localparam logic [64:0] LIMIT = 65'(NB);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_ready;
  logic        r_rsp_valid;
  logic        r_err;
  logic [63:0] r_rdata;

  logic [7:0]  r_mem [NB];

  logic [3:0]    w_nb;
  logic [2:0]    w_mask;
  logic [64:0]   w_end;
  logic          w_err;
  logic [AW-1:0] w_base;
  logic          w_commit;
  logic [63:0]   w_raw;
  logic [63:0]   w_load;

  assign w_nb     = 4'd1 << r_size;
  assign w_mask   = 3'(w_nb - 4'd1);
  // 65-bit sum so addresses near 2^64 cannot wrap into range
  assign w_end    = {1'b0, r_addr} + {61'd0, w_nb};
  assign w_err    = (|(r_addr[2:0] & w_mask)) || (w_end > LIMIT);
  assign w_base   = r_addr[AW-1:0];
  assign w_commit = (r_state == BUSY) && (r_cnt == 4'd0);

  always_comb begin
    w_raw = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < w_nb) begin
        w_raw[8*i +: 8] = r_mem[w_base + AW'(i)];
      end
    end
  end

  always_comb begin
    w_load = w_raw;
    unique case (r_size)
      2'd0: w_load = r_uns ? {56'd0, w_raw[7:0]}
                           : {{56{w_raw[7]}}, w_raw[7:0]};
      2'd1: w_load = r_uns ? {48'd0, w_raw[15:0]}
                           : {{48{w_raw[15]}}, w_raw[15:0]};
      2'd2: w_load = r_uns ? {32'd0, w_raw[31:0]}
                           : {{32{w_raw[31]}}, w_raw[31:0]};
      2'd3: w_load = w_raw;
    endcase
  end

  // No reset on the array; r_state is forced to IDLE by reset,
  // so a pending store never commits once reset has hit.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < w_nb) begin
          r_mem[w_base + AW'(i)] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_uns       <= 1'b0;
      r_addr      <= 64'd0;
      r_wdata     <= 64'd0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 64'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_ready <= 1'b0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_err       <= w_err;
            r_rdata     <= (w_err || r_we) ? 64'd0 : w_load;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 64'd0;
            r_ready     <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: vector table plus
// back-pressure and reset-during-store sequences.
module tb_data_mem_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  data_mem_unit #(.DEPTH(1024), .WAIT_CYCLES(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic we,
                              input logic [1:0] sz, input logic uns,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] rd, input logic er);
    vec_t v;
    v.name = nm; v.we = we; v.size = sz; v.uns = uns;
    v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    @(negedge clk);
    chk({v.name, ".ready"}, 64'(req_ready), 64'd1);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    // scramble request fields; they must be ignored now
    req_valid    = 1'b0;
    req_we       = ~v.we;
    req_size     = ~v.size;
    req_unsigned = ~v.uns;
    req_addr     = 64'h18;
    req_wdata    = '1;
  endtask

  task automatic txn(input vec_t v);
    int lat;
    issue(v);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({v.name, ".lat"}, 64'(lat), 64'd2);
    chk({v.name, ".rdata"}, rsp_rdata, v.exp_rd);
    chk({v.name, ".err"}, 64'(rsp_err), 64'(v.exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({v.name, ".idle"}, {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    vec_t bp;
    vec_t st;
    logic [63:0] hold_rd;
    int seen;

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 64'd0;
    req_wdata    = 64'd0;
    rsp_ready    = 1'b0;

    vecs.push_back(mk("sd10",   1, 3, 0, 64'h10,
      64'h1122334455667788, 64'h0, 0));
    vecs.push_back(mk("ld10",   0, 3, 0, 64'h10,
      64'h0, 64'h1122334455667788, 0));
    vecs.push_back(mk("sb13",   1, 0, 0, 64'h13,
      64'hDEADBEEFCAFE12AB, 64'h0, 0));
    vecs.push_back(mk("lb13",   0, 0, 0, 64'h13,
      64'h0, 64'hFFFFFFFFFFFFFFAB, 0));
    vecs.push_back(mk("lbu13",  0, 0, 1, 64'h13,
      64'h0, 64'hAB, 0));
    vecs.push_back(mk("ld10b",  0, 3, 0, 64'h10,
      64'h0, 64'h11223344AB667788, 0));
    vecs.push_back(mk("lhu12",  0, 1, 1, 64'h12,
      64'h0, 64'hAB66, 0));
    vecs.push_back(mk("lh12",   0, 1, 0, 64'h12,
      64'h0, 64'hFFFFFFFFFFFFAB66, 0));
    vecs.push_back(mk("lw10",   0, 2, 0, 64'h10,
      64'h0, 64'hFFFFFFFFAB667788, 0));
    vecs.push_back(mk("lwu14",  0, 2, 1, 64'h14,
      64'h0, 64'h11223344, 0));
    vecs.push_back(mk("lh11",   0, 1, 0, 64'h11,
      64'h0, 64'h0, 1));
    vecs.push_back(mk("sw12",   1, 2, 0, 64'h12,
      64'hFFFFFFFF, 64'h0, 1));
    vecs.push_back(mk("ld10c",  0, 3, 0, 64'h10,
      64'h0, 64'h11223344AB667788, 0));
    vecs.push_back(mk("sd1ff8", 1, 3, 0, 64'h1FF8,
      64'h0123456789ABCDEF, 64'h0, 0));
    vecs.push_back(mk("sw1ffc", 1, 2, 0, 64'h1FFC,
      64'h80000000, 64'h0, 0));
    vecs.push_back(mk("lw1ffc", 0, 2, 0, 64'h1FFC,
      64'h0, 64'hFFFFFFFF80000000, 0));
    vecs.push_back(mk("sw1ffe", 1, 2, 0, 64'h1FFE,
      64'hFFFFFFFF, 64'h0, 1));
    vecs.push_back(mk("sd2000", 1, 3, 0, 64'h2000,
      64'hFFFFFFFFFFFFFFFF, 64'h0, 1));
    vecs.push_back(mk("ld1ff8", 0, 3, 0, 64'h1FF8,
      64'h0, 64'h8000000089ABCDEF, 0));
    vecs.push_back(mk("ldwrap", 0, 3, 0, 64'hFFFFFFFFFFFFFFF8,
      64'h0, 64'h0, 1));
    vecs.push_back(mk("lbhigh", 0, 0, 0, 64'h0000000100000010,
      64'h0, 64'h0, 1));
    vecs.push_back(mk("lbu1fff", 0, 0, 1, 64'h1FFF,
      64'h0, 64'h80, 0));
    vecs.push_back(mk("sh1fff", 1, 1, 0, 64'h1FFF,
      64'h0, 64'h0, 1));
    vecs.push_back(mk("lh1ffe", 0, 1, 0, 64'h1FFE,
      64'h0, 64'hFFFFFFFFFFFF8000, 0));

    #12;
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.rsp_rdata", rsp_rdata, 64'd0);
    chk("rst.rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      txn(vecs[i]);
    end

    // back-pressure: hold the response for 5 cycles
    bp = mk("bp", 0, 3, 0, 64'h10, 64'h0, 64'h11223344AB667788, 0);
    issue(bp);
    seen = 0;
    while (!rsp_valid && seen < 20) begin
      @(posedge clk);
      #1;
      seen++;
    end
    chk("bp.lat", 64'(seen), 64'd2);
    hold_rd = rsp_rdata;
    chk("bp.rdata", hold_rd, 64'h11223344AB667788);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      req_addr = 64'(c);
      chk("bp.hold", {61'd0, rsp_valid, req_ready, rsp_err}, 64'h4);
      chk("bp.stable", rsp_rdata, 64'h11223344AB667788);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp.release", {62'd0, rsp_valid, req_ready}, 64'd1);

    // reset in BUSY drops the pending store
    txn(mk("sd20", 1, 3, 0, 64'h20,
      64'h5555AAAA5555AAAA, 64'h0, 0));
    st = mk("sd20x", 1, 3, 0, 64'h20, 64'hFEEDFACE0BADF00D, 64'h0, 0);
    issue(st);
    rst_n = 1'b0;
    #2;
    chk("rstb.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstb.req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    chk("rstb.no_rsp", 64'(seen), 64'd0);
    txn(mk("ld20", 0, 3, 0, 64'h20,
      64'h0, 64'h5555AAAA5555AAAA, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of 64-bit memory words (byte capacity DEPTH*8).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the extra access latency in cycles (0..15 legal).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 The block SHALL have port req_unsigned  input  1  load zero-extend when 1, sign-extend when 0; ignored for stores and size 3.
REQ-010 The block SHALL have port req_addr  input  64  byte address.
REQ-011 The block SHALL have port req_wdata  input  64  store data; low 8*2^size bits used.
REQ-012 The block SHALL have port rsp_valid  output  1  response present.
REQ-013 The block SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-014 The block SHALL have port rsp_rdata  output  64  load result (0 for stores and errors).
REQ-015 The block SHALL have port rsp_err  output  1  invalid address: misaligned or out of range.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-017 A request SHALL be accepted on an edge with req_valid&&req_ready; all request fields are latched then, and the FSM goes IDLE->BUSY with the wait counter loaded to WAIT_CYCLES.
REQ-018 In BUSY the counter SHALL decrement each cycle; on the edge where it is 0, the memory operation executes and the FSM goes to RESP; accept-to-rsp_valid latency = WAIT_CYCLES+1 cycles.
REQ-019 In RESP the outputs SHALL hold stable until rsp_valid&&rsp_ready, then the FSM goes to IDLE; back-pressure is unbounded.
REQ-020 The error condition SHALL be addr mod 2^size != 0 OR addr+2^size > DEPTH*8, evaluated on the latched address with full 64-bit compare (no truncation).
REQ-021 On error: no memory byte SHALL change, rsp_err=1, rsp_rdata=0; latency is unchanged.
REQ-022 A store SHALL write exactly 2^size bytes, little-endian, starting at addr; all other bytes are unchanged.
REQ-023 A load SHALL return 2^size bytes, little-endian, zero- or sign-extended to 64 bits per req_unsigned.
REQ-024 A valid access SHALL return rsp_err=0; a store SHALL return rsp_rdata=0.
REQ-025 req_* changes while not in IDLE SHALL have no effect.
REQ-026 A load SHALL observe every store whose response completed earlier (read-after-write through memory).
REQ-027 Memory array contents SHALL NOT be reset; their initial value is undefined.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, and req_ready=1 after release.
REQ-029 Reset asserted before the commit edge of REQ-018 SHALL drop the pending store (memory unchanged); reset does not undo a store already committed.
REQ-030 The first accepted request after rst_n rises SHALL behave exactly as per REQ-017..024.

Verification (DEPTH=1024, WAIT_CYCLES=1)
REQ-031 Store double 0x1122334455667788 @0x10, then load double @0x10 -> rsp_valid 2 cycles after each accept; rdata=0x1122334455667788, err=0.
REQ-032 After REQ-031: store byte 0xAB @0x13; load byte signed @0x13 -> 0xFFFFFFFFFFFFFFAB; unsigned -> 0xAB; load double @0x10 -> 0x11223344AB667788.
REQ-033 Load half @0x11, store word @0x1FFC... actually @0x1FFE -> err=1 (misaligned / out of range); store double @0x2000 -> err=1; a following load @0x1FF8 shows no change.
REQ-034 Load word @0x1FFC after a store word 0x80000000 there -> rdata=0xFFFFFFFF80000000, err=0.
REQ-035 Hold rsp_ready=0 for 5 cycles on a response -> rsp_valid/rdata stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-036 Pulse rst_n low during BUSY of a store to 0x20 -> rsp_valid never asserts; a subsequent load @0x20 returns the pre-store value.
